// File: rtl/syn_lb_master_pkg.sv
// Shared types and defaults for the local-bus initiator.
package syn_lb_master_pkg;

   localparam int unsigned LB_DWIDTH       = 32;
   localparam int unsigned LB_AWIDTH       = 16;
   localparam int unsigned LB_TIMEOUT_DEF  = 255;
   localparam logic [LB_DWIDTH-1:0] LB_TIMEOUT_DATA = 32'hDEAD_DEAD;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } lb_mstr_fsm_t;

   typedef struct packed {
      logic                 wr;
      logic                 timeout;
      logic [LB_DWIDTH-1:0] data;
   } lb_rsp_t;

endpackage

// File: rtl/syn_lb_master_if.sv
// Command, response and LB master signals of syn_lb_master.
// master = initiator view, slave = host/responder view.
interface syn_lb_master_if
   import syn_lb_master_pkg::*;
#(
   parameter int unsigned P_LB_DWIDTH = LB_DWIDTH,
   parameter int unsigned P_LB_AWIDTH = LB_AWIDTH
) ();

   logic                   cmd_valid_ih;
   logic                   cmd_ready_oh;
   logic                   cmd_wr_ih;
   logic [P_LB_AWIDTH-1:0] cmd_addr_id;
   logic [P_LB_DWIDTH-1:0] cmd_data_id;
   logic                   rsp_valid_oh;
   logic                   rsp_ready_ih;
   logic                   rsp_wr_od;
   logic                   rsp_timeout_od;
   logic [P_LB_DWIDTH-1:0] rsp_data_od;
   logic                   lb_rd_en_oh;
   logic                   lb_wr_en_oh;
   logic [P_LB_AWIDTH-1:0] lb_addr_od;
   logic [P_LB_DWIDTH-1:0] lb_wr_data_od;
   logic                   lb_rd_valid_ih;
   logic                   lb_wr_valid_ih;
   logic [P_LB_DWIDTH-1:0] lb_rd_data_id;
   logic                   lb_stray_oh;

   modport master (
      input  cmd_valid_ih, cmd_wr_ih, cmd_addr_id, cmd_data_id, rsp_ready_ih,
             lb_rd_valid_ih, lb_wr_valid_ih, lb_rd_data_id,
      output cmd_ready_oh, rsp_valid_oh, rsp_wr_od, rsp_timeout_od, rsp_data_od,
             lb_rd_en_oh, lb_wr_en_oh, lb_addr_od, lb_wr_data_od, lb_stray_oh
   );

   modport slave (
      output cmd_valid_ih, cmd_wr_ih, cmd_addr_id, cmd_data_id, rsp_ready_ih,
             lb_rd_valid_ih, lb_wr_valid_ih, lb_rd_data_id,
      input  cmd_ready_oh, rsp_valid_oh, rsp_wr_od, rsp_timeout_od, rsp_data_od,
             lb_rd_en_oh, lb_wr_en_oh, lb_addr_od, lb_wr_data_od, lb_stray_oh
   );

endinterface

// File: rtl/syn_lb_master.sv
// Local-bus initiator: one outstanding read/write, strobe, wait for ack or timeout,
// then hold the response until the consumer takes it.
module syn_lb_master
   import syn_lb_master_pkg::*;
#(
   parameter int unsigned           P_LB_DWIDTH    = LB_DWIDTH,
   parameter int unsigned           P_LB_AWIDTH    = LB_AWIDTH,
   parameter int unsigned           P_TIMEOUT      = LB_TIMEOUT_DEF,
   parameter logic [P_LB_DWIDTH-1:0] P_TIMEOUT_DATA = LB_TIMEOUT_DATA
) (
   input  logic               clk_ir,
   input  logic               rst_ih,
   syn_lb_master_if.master    lb_bus
);

   localparam int unsigned    CW       = $clog2(P_TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(P_TIMEOUT - 1);

   lb_mstr_fsm_t           r_state;
   logic                   r_wr;
   logic [P_LB_AWIDTH-1:0] r_addr;
   logic [P_LB_DWIDTH-1:0] r_wdata;
   logic                   r_rd_en;
   logic                   r_wr_en;
   logic [CW-1:0]          r_cnt;
   lb_rsp_t                r_rsp;
   logic                   r_rsp_valid;
   logic                   r_stray;

   logic w_any_valid;
   logic w_hit;
   logic w_mismatch;

   assign w_any_valid = lb_bus.lb_rd_valid_ih | lb_bus.lb_wr_valid_ih;
   assign w_hit       = r_wr ? lb_bus.lb_wr_valid_ih : lb_bus.lb_rd_valid_ih;
   assign w_mismatch  = r_wr ? lb_bus.lb_rd_valid_ih : lb_bus.lb_wr_valid_ih;

   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         r_state     <= IDLE;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rd_en     <= 1'b0;
         r_wr_en     <= 1'b0;
         r_cnt       <= '0;
         r_rsp       <= '0;
         r_rsp_valid <= 1'b0;
         r_stray     <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_stray <= 1'b0;
         case (r_state)
            IDLE: begin
               r_stray <= w_any_valid;
               if (lb_bus.cmd_valid_ih) begin
                  r_wr    <= lb_bus.cmd_wr_ih;
                  r_addr  <= lb_bus.cmd_addr_id;
                  r_wdata <= lb_bus.cmd_data_id;
                  r_rd_en <= ~lb_bus.cmd_wr_ih;
                  r_wr_en <= lb_bus.cmd_wr_ih;
                  r_state <= ISSUE;
               end
            end
            // Responder outputs are registered, so anything seen here predates the strobe.
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               r_stray <= w_mismatch;
               if (w_hit) begin
                  r_rsp       <= '{wr: r_wr, timeout: 1'b0,
                                   data: r_wr ? '0 : lb_bus.lb_rd_data_id};
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_rsp       <= '{wr: r_wr, timeout: 1'b1,
                                   data: r_wr ? '0 : P_TIMEOUT_DATA};
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               r_stray <= w_any_valid;
               if (lb_bus.rsp_ready_ih) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign lb_bus.cmd_ready_oh   = (r_state == IDLE) & ~rst_ih;
   assign lb_bus.rsp_valid_oh   = r_rsp_valid;
   assign lb_bus.rsp_wr_od      = r_rsp.wr;
   assign lb_bus.rsp_timeout_od = r_rsp.timeout;
   assign lb_bus.rsp_data_od    = r_rsp.data;
   assign lb_bus.lb_rd_en_oh    = r_rd_en;
   assign lb_bus.lb_wr_en_oh    = r_wr_en;
   assign lb_bus.lb_addr_od     = r_addr;
   assign lb_bus.lb_wr_data_od  = r_wdata;
   assign lb_bus.lb_stray_oh    = r_stray;

endmodule
